// File: rtl/fpdiv.sv
// binary32 divider datapath: Goldschmidt iteration on one shared 60-bit (2.58) multiplier,
// stepped by an external controller, with a remainder step to fix the final rounding.
module fpdiv (
  output logic [31:0] final_ans,
  input  logic [31:0] inputNum,
  input  logic [31:0] inputDenom,
  input  logic        rm,
  input  logic [1:0]  op_type,
  input  logic        start,
  input  logic        reset,
  input  logic        clk,
  input  logic        en_a,
  input  logic        en_b,
  input  logic        en_rem,
  input  logic [1:0]  sel_mux3,
  input  logic [1:0]  sel_mux4
);

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
  } fp_t;

  localparam logic [59:0] TWO  = {2'b10, 58'd0};
  localparam logic [59:0] BIAS = 60'd1 << 18;   // 2^-40

  fp_t         num_q, den_q;
  logic [59:0] a_q, b_q;
  logic [60:0] r_q, r_d;
  logic        rvld_q;
  logic [31:0] ans_q, ans_d;

  logic [59:0]  nm, dm, ia, c, m, mfull, op1, op2, p;
  logic [9:0]   ia10;
  logic [119:0] prod;
  logic [59:0]  qb, qn;
  logic         norm, inc, carry;
  logic [23:0]  qm;
  logic [24:0]  qr;
  logic signed [9:0] ex;
  logic         sgn;
  logic         n_nan, d_nan, n_inf, d_inf, n_zero, d_zero;

  assign nm = {2'b01, num_q.f, 35'd0};
  assign dm = {2'b01, den_q.f, 35'd0};

  // Reciprocal seed: 1/(1+(i+0.5)/16) to 10 fractional bits
  always_comb begin
    ia10 = 10'd0;
    case (den_q.f[22:19])
      4'd0:  ia10 = 10'd993;
      4'd1:  ia10 = 10'd936;
      4'd2:  ia10 = 10'd886;
      4'd3:  ia10 = 10'd840;
      4'd4:  ia10 = 10'd799;
      4'd5:  ia10 = 10'd762;
      4'd6:  ia10 = 10'd728;
      4'd7:  ia10 = 10'd697;
      4'd8:  ia10 = 10'd669;
      4'd9:  ia10 = 10'd643;
      4'd10: ia10 = 10'd618;
      4'd11: ia10 = 10'd596;
      4'd12: ia10 = 10'd575;
      4'd13: ia10 = 10'd555;
      4'd14: ia10 = 10'd537;
      default: ia10 = 10'd520;
    endcase
  end
  assign ia = {2'b00, ia10, 48'd0};
  assign c  = TWO - b_q;

  // Biased-down quotient guarantees qm is never above the true truncation
  assign qb    = a_q - BIAS;
  assign norm  = (qb[59:58] == 2'b00);
  assign qn    = norm ? {qb[58:0], 1'b0} : qb;
  assign qm    = qn[58:35];
  assign mfull = {1'b0, qm, 1'b1, 34'd0};
  assign m     = norm ? {1'b0, mfull[59:1]} : mfull;

  always_comb begin
    op1 = nm;
    case (sel_mux4)
      2'b00:   op1 = nm;
      2'b01:   op1 = dm;
      2'b10:   op1 = a_q;
      default: op1 = b_q;
    endcase
    if (sel_mux3 == 2'b10) op1 = m;
  end

  always_comb begin
    op2 = ia;
    case (sel_mux3)
      2'b01:   op2 = c;
      2'b10:   op2 = dm;
      default: op2 = ia;
    endcase
  end

  assign prod = {60'd0, op1} * {60'd0, op2};
  assign p    = prod[117:58];
  assign r_d  = {1'b0, nm} - {1'b0, p};

  // Sign of R places the true quotient relative to the midpoint qm + ulp/2
  assign inc   = rm & ~r_q[60] & ((r_q != 61'd0) | qm[0]);
  assign qr    = {1'b0, qm} + {24'd0, inc};
  assign carry = qr[24];
  assign ex    = $signed({2'b00, num_q.e}) - $signed({2'b00, den_q.e}) + 10'sd127
               - $signed({9'd0, norm}) + $signed({9'd0, carry});
  assign sgn   = num_q.s ^ den_q.s;

  assign n_nan  = (num_q.e == 8'hFF) && (num_q.f != 23'd0);
  assign d_nan  = (den_q.e == 8'hFF) && (den_q.f != 23'd0);
  assign n_inf  = (num_q.e == 8'hFF) && (num_q.f == 23'd0);
  assign d_inf  = (den_q.e == 8'hFF) && (den_q.f == 23'd0);
  assign n_zero = (num_q.e == 8'h00);
  assign d_zero = (den_q.e == 8'h00);

  always_comb begin
    ans_d = {sgn, ex[7:0], carry ? 23'd0 : qr[22:0]};
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf))
      ans_d = 32'h7FC0_0000;
    else if (d_zero || n_inf)
      ans_d = {sgn, 8'hFF, 23'd0};
    else if (n_zero || d_inf)
      ans_d = {sgn, 31'd0};
    else if (ex >= 10'sd255)
      ans_d = {sgn, 8'hFF, 23'd0};
    else if (ex <= 10'sd0)
      ans_d = {sgn, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q  <= '0;
      den_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      rvld_q <= 1'b0;
      ans_q  <= '0;
    end else begin
      if (start) begin
        num_q <= inputNum;
        den_q <= inputDenom;
      end
      if (en_a)   a_q <= p;
      if (en_b)   b_q <= p;
      if (en_rem) r_q <= r_d;
      rvld_q <= en_rem;
      if (rvld_q) ans_q <= ans_d;
    end
  end

  assign final_ans = ans_q;

  logic unused;
  assign unused = ^{op_type, prod[119:118], prod[57:0], qn[59], qn[34:0], qr[23]};

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed vector table, protocol corner sequences,
// and random operands against an exact integer-division rounding model.
module tb_fpdiv;

  logic [31:0] final_ans, inputNum, inputDenom;
  logic        rm, start, reset, clk, en_a, en_b, en_rem;
  logic [1:0]  op_type, sel_mux3, sel_mux4;

  int checks = 0;
  int errors = 0;

  fpdiv dut (
    .final_ans(final_ans), .inputNum(inputNum), .inputDenom(inputDenom), .rm(rm),
    .op_type(op_type), .start(start), .reset(reset), .clk(clk), .en_a(en_a),
    .en_b(en_b), .en_rem(en_rem), .sel_mux3(sel_mux3), .sel_mux4(sel_mux4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [31:0] e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Exact quotient by integer division, then IEEE rounding with flush-to-zero
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic r);
    logic   s, an, bn, ai, bi, az, bz;
    int     e;
    longint mn, md, num, q, rem;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
    if (bz || ai) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    mn = longint'({1'b1, a[22:0]});
    md = longint'({1'b1, b[22:0]});
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (mn >= md) num = mn << 23;
    else begin
      num = mn << 24;
      e--;
    end
    q   = num / md;
    rem = num % md;
    if (r && ((2 * rem > md) || ((2 * rem == md) && (q % 2 == 1)))) q++;
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic step(input logic ea, input logic eb, input logic er,
                      input logic [1:0] s3, input logic [1:0] s4);
    @(negedge clk);
    en_a = ea; en_b = eb; en_rem = er; sel_mux3 = s3; sel_mux4 = s4;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    inputNum = a; inputDenom = b; rm = r; start = 1'b1;
    en_a = 0; en_b = 0; en_rem = 0;
  endtask

  task automatic first_steps();
    step(1, 0, 0, 2'b00, 2'b00);
    step(0, 1, 0, 2'b00, 2'b01);
  endtask

  task automatic pair_step();
    step(1, 0, 0, 2'b01, 2'b10);
    step(0, 1, 0, 2'b01, 2'b11);
  endtask

  task automatic idle();
    @(negedge clk);
    en_a = 0; en_b = 0; en_rem = 0; start = 0; sel_mux3 = 2'b00; sel_mux4 = 2'b00;
  endtask

  // Full 13-step sequence; early = output one half-cycle after the R edge
  task automatic divide(input logic [31:0] a, input logic [31:0] b, input logic r,
                        output logic [31:0] early, output logic [31:0] res);
    load_ops(a, b, r);
    first_steps();
    repeat (5) pair_step();
    step(0, 0, 1, 2'b10, 2'b00);
    idle();
    early = final_ans;
    @(negedge clk);
    res = final_ans;
  endtask

  vec_t        tbl [0:19];
  logic [31:0] early, res, prev, ra, rb, rnd, expv;
  logic [7:0]  xa, xb;

  initial begin
    tbl[0]  = '{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3FC00000};
    tbl[1]  = '{32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000};
    tbl[2]  = '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB};
    tbl[3]  = '{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA};
    tbl[4]  = '{32'h40000000, 32'h40400000, 1'b1, 32'h3F2AAAAB};
    tbl[5]  = '{32'h40000000, 32'h40400000, 1'b0, 32'h3F2AAAAA};
    tbl[6]  = '{32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000};
    tbl[8]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F800000};
    tbl[9]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
    tbl[10] = '{32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000};
    tbl[11] = '{32'h00000000, 32'hBF800000, 1'b1, 32'h80000000};
    tbl[12] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h80000000};
    tbl[13] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000};
    tbl[14] = '{32'h00400000, 32'h3F800000, 1'b1, 32'h00000000};
    tbl[15] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000};
    tbl[16] = '{32'h00800000, 32'h40000000, 1'b1, 32'h00000000};
    tbl[17] = '{32'h3F800000, 32'h3FFFFFFF, 1'b1, 32'h3F000001};
    tbl[18] = '{32'h7F7FFFFF, 32'h3F800000, 1'b1, 32'h7F7FFFFF};
    tbl[19] = '{32'hBF800000, 32'h00000000, 1'b1, 32'hFF800000};

    reset = 1; start = 0; en_a = 0; en_b = 0; en_rem = 0; rm = 1;
    op_type = 2'b00; sel_mux3 = 2'b00; sel_mux4 = 2'b00;
    inputNum = 32'h0; inputDenom = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_value", final_ans, 32'h0);
    reset = 0;
    repeat (4) @(negedge clk);
    check("idle_after_reset", final_ans, 32'h0);

    prev = 32'h0;
    for (int i = 0; i < 20; i++) begin
      divide(tbl[i].a, tbl[i].b, tbl[i].r, early, res);
      check($sformatf("latency_hold[%0d]", i), early, prev);
      check($sformatf("vec[%0d] %h/%h rm=%0d", i, tbl[i].a, tbl[i].b, tbl[i].r), res, tbl[i].e);
      prev = tbl[i].e;
    end

    // New operands loaded without an R step must not disturb the held result
    load_ops(32'h40A00000, 32'h40400000, 1'b1);
    repeat (3) @(negedge clk);
    idle();
    check("hold_across_start", final_ans, prev);

    // Abort mid-sequence with reset, then a clean operation
    load_ops(32'h3F800000, 32'h40400000, 1'b1);
    first_steps();
    pair_step();
    @(negedge clk);
    reset = 1; en_a = 0; en_b = 0; en_rem = 0; start = 0;
    @(negedge clk);
    reset = 0;
    check("midseq_reset_clears", final_ans, 32'h0);
    repeat (2) @(negedge clk);
    check("midseq_reset_idle", final_ans, 32'h0);
    divide(32'h40000000, 32'h40400000, 1'b1, early, res);
    check("after_abort_latency", early, 32'h0);
    check("after_abort_result", res, 32'h3F2AAAAB);

    for (int i = 0; i < 2000; i++) begin
      if (i % 4 == 0) begin
        xa = 8'($urandom_range(1, 254));
        xb = 8'($urandom_range(1, 254));
      end else begin
        xa = 8'($urandom_range(64, 190));
        xb = 8'($urandom_range(64, 190));
      end
      rnd = $urandom();
      ra  = {rnd[31], xa, rnd[22:0]};
      rnd = $urandom();
      rb  = {rnd[31], xb, rnd[22:0]};
      expv = ref_div(ra, rb, 1'b1);
      divide(ra, rb, 1'b1, early, res);
      check($sformatf("rand[%0d] %h/%h", i, ra, rb), res, expv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
